// File: rtl/btn_debounce_array.sv
// Multi-channel push-button conditioner: synchronizer, stability-count debounce, edge pulses.
// Optional long-press pulse per channel when BTN_LONG_PRESS_EN is defined.
//
// state        | meaning
// LOW_STABLE   | level 0, sync agrees, count idle
// LOW_CONFIRM  | level 0, sync high, counting toward a rise
// HIGH_STABLE  | level 1, sync agrees, count idle
// HIGH_CONFIRM | level 1, sync low, counting toward a fall
module btn_debounce_array #(
    parameter int N_CH          = 5,
    parameter int STABLE_CYCLES = 130000,
    parameter int SYNC_STAGES   = 2,
    parameter int HOLD_CYCLES   = 100000000
) (
    input  logic            clk,
    input  logic            buttom_rst,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_rise,
    output logic [N_CH-1:0] btn_fall,
    output logic [N_CH-1:0] long_press
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOW_STABLE   = 2'b00,
        LOW_CONFIRM  = 2'b01,
        HIGH_STABLE  = 2'b10,
        HIGH_CONFIRM = 2'b11
    } deb_state_e;

    if (N_CH < 1 || STABLE_CYCLES < 1 || SYNC_STAGES < 2 || HOLD_CYCLES < 1) begin : g_bad_params
        $error("btn_debounce_array: illegal parameter value");
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync;
        deb_state_e             state_q, state_d;
        logic [CW-1:0]          cnt_q, cnt_d;
        logic                   rise_q, rise_d;
        logic                   fall_q, fall_d;
        logic                   level_d;

        assign sync = sync_q[SYNC_STAGES-1];

        always_ff @(posedge clk or posedge buttom_rst) begin
            if (buttom_rst) begin
                sync_q  <= '0;
                state_q <= LOW_STABLE;
                cnt_q   <= '0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_raw[g]};
                state_q <= state_d;
                cnt_q   <= cnt_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            case (state_q)
                LOW_STABLE, LOW_CONFIRM: begin
                    if (!sync) begin
                        state_d = LOW_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = HIGH_STABLE;
                        cnt_d   = '0;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = LOW_CONFIRM;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
                HIGH_STABLE, HIGH_CONFIRM: begin
                    if (sync) begin
                        state_d = HIGH_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = LOW_STABLE;
                        cnt_d   = '0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = HIGH_CONFIRM;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = LOW_STABLE;
                    cnt_d   = '0;
                end
            endcase
            level_d = (state_d == HIGH_STABLE) || (state_d == HIGH_CONFIRM);
        end

        assign btn_level[g] = (state_q == HIGH_STABLE) || (state_q == HIGH_CONFIRM);
        assign btn_rise[g]  = rise_q;
        assign btn_fall[g]  = fall_q;

`ifdef BTN_LONG_PRESS_EN
        localparam int HW = $clog2(HOLD_CYCLES + 1);
        localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
        localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

        logic [HW-1:0] hold_q, hold_d;
        logic          lp_q, lp_d;

        // Counter restarts on the edge the level rises, so it reads k at edge rise+k.
        always_comb begin
            hold_d = hold_q;
            lp_d   = 1'b0;
            if (!level_d || rise_d) begin
                hold_d = '0;
            end else if (hold_q != HOLD_MAX) begin
                hold_d = hold_q + HW'(1);
                lp_d   = (hold_q == HOLD_LAST);
            end
        end

        always_ff @(posedge clk or posedge buttom_rst) begin
            if (buttom_rst) begin
                hold_q <= '0;
                lp_q   <= 1'b0;
            end else begin
                hold_q <= hold_d;
                lp_q   <= lp_d;
            end
        end

        assign long_press[g] = lp_q;
`else
        assign long_press[g] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_btn_debounce_array.sv
// Scoreboard bench for btn_debounce_array: expected pulses are queued with their edge
// number when stimulus is driven and matched against pulses seen on the falling clock edge.
module tb_btn_debounce_array;

    localparam int N_CH          = 5;
    localparam int STABLE_CYCLES = 4;
    localparam int SYNC_STAGES   = 2;
    localparam int HOLD_CYCLES   = 10;
    localparam int LAT           = SYNC_STAGES + STABLE_CYCLES;
    localparam int K_RISE = 0, K_FALL = 1, K_LP = 2;

    logic            clk = 1'b0;
    logic            buttom_rst;
    logic [N_CH-1:0] btn_raw;
    logic [N_CH-1:0] btn_level, btn_rise, btn_fall, long_press;

    btn_debounce_array #(
        .N_CH(N_CH), .STABLE_CYCLES(STABLE_CYCLES),
        .SYNC_STAGES(SYNC_STAGES), .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .clk(clk), .buttom_rst(buttom_rst), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_rise(btn_rise),
        .btn_fall(btn_fall), .long_press(long_press)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int cyc;
        int ch;
        int kind;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic push(input int cyc, input int ch, input int kind);
        ev_t e;
        e.cyc  = cyc;
        e.ch   = ch;
        e.kind = kind;
        exp_q.push_back(e);
    endtask

    task automatic push_lp(input int cyc, input int ch);
`ifdef BTN_LONG_PRESS_EN
        push(cyc, ch, K_LP);
`else
        if (cyc < 0 || ch < 0) $display("bad long-press event");
`endif
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        for (int ch = 0; ch < N_CH; ch++) begin
            if (btn_rise[ch] || btn_fall[ch])
                check($sformatf("rise_fall_excl_ch%0d", ch), int'(btn_rise[ch] & btn_fall[ch]), 0);
            for (int k = 0; k < 3; k++) begin
                logic p;
                int   idx;
                p = (k == K_RISE) ? btn_rise[ch] : (k == K_FALL) ? btn_fall[ch] : long_press[ch];
                if (p) begin
                    idx = -1;
                    for (int j = 0; j < exp_q.size(); j++)
                        if (idx < 0 && exp_q[j].ch == ch && exp_q[j].kind == k) idx = j;
                    if (idx < 0) begin
                        check($sformatf("unexpected_ch%0d_k%0d_at%0d", ch, k, edge_n), 1, 0);
                    end else begin
                        check($sformatf("edge_ch%0d_k%0d", ch, k), edge_n, exp_q[idx].cyc);
                        exp_q.delete(idx);
                    end
                end
            end
        end
    end

    initial begin
        int t, r;
        btn_raw    = '0;
        buttom_rst = 1'b1;
        wait_cyc(3);
        check("rst_level", int'(btn_level), 0);
        check("rst_rise",  int'(btn_rise), 0);
        check("rst_fall",  int'(btn_fall), 0);
        check("rst_lp",    int'(long_press), 0);
        buttom_rst = 1'b0;
        wait_cyc(2);

        // Clean press on ch0, held long enough for a long press
        btn_raw[0] = 1'b1;
        t = edge_n;
        push(t + LAT, 0, K_RISE);
        push_lp(t + LAT + HOLD_CYCLES, 0);
        wait_cyc(LAT - 1);
        check("press_level_early", int'(btn_level), 0);
        wait_cyc(1);
        check("press_level", int'(btn_level), 5'b00001);
        wait_cyc(19);
        btn_raw[0] = 1'b0;
        push(edge_n + LAT, 0, K_FALL);
        wait_cyc(10);
        check("release_level", int'(btn_level), 0);

        // Short press: debounced high for 5 cycles, no long press
        btn_raw[0] = 1'b1;
        t = edge_n;
        push(t + LAT, 0, K_RISE);
        wait_cyc(5);
        btn_raw[0] = 1'b0;
        push(t + 5 + LAT, 0, K_FALL);
        wait_cyc(20);
        check("short_level", int'(btn_level), 0);

        // Bounce on ch1: 3-cycle burst, 1 low, then held
        t = edge_n;
        btn_raw[1] = 1'b1;
        wait_cyc(3);
        btn_raw[1] = 1'b0;
        wait_cyc(1);
        btn_raw[1] = 1'b1;
        push(t + 4 + LAT, 1, K_RISE);
        push_lp(t + 4 + LAT + HOLD_CYCLES, 1);
        wait_cyc(12);
        check("bounce_level", int'(btn_level), 5'b00010);

        // ch2 and ch3 pressed together, released at different times
        btn_raw[3:2] = 2'b11;
        t = edge_n;
        push(t + LAT, 2, K_RISE);
        push(t + LAT, 3, K_RISE);
        push_lp(t + LAT + HOLD_CYCLES, 3);
        wait_cyc(8);
        check("pair_level", int'(btn_level), 5'b01110);
        btn_raw[2] = 1'b0;
        push(edge_n + LAT, 2, K_FALL);
        wait_cyc(8);
        btn_raw[3] = 1'b0;
        push(edge_n + LAT, 3, K_FALL);
        wait_cyc(10);
        check("pair_released_level", int'(btn_level), 5'b00010);

        // Reset while ch4 is mid-count (cnt=2); ch1 held through reset
        btn_raw[4] = 1'b1;
        wait_cyc(4);
        buttom_rst = 1'b1;
        #1;
        check("rstmid_level", int'(btn_level), 0);
        check("rstmid_rise",  int'(btn_rise), 0);
        check("rstmid_fall",  int'(btn_fall), 0);
        check("rstmid_lp",    int'(long_press), 0);
        wait_cyc(3);
        buttom_rst = 1'b0;
        r = edge_n;
        push(r + LAT, 4, K_RISE);
        push(r + LAT, 1, K_RISE);
        push_lp(r + LAT + HOLD_CYCLES, 4);
        push_lp(r + LAT + HOLD_CYCLES, 1);
        wait_cyc(LAT - 1);
        check("after_rst_early", int'(btn_level), 0);
        wait_cyc(1);
        check("after_rst_level", int'(btn_level), 5'b10010);
        wait_cyc(14);

        btn_raw = '0;
        push(edge_n + LAT, 1, K_FALL);
        push(edge_n + LAT, 4, K_FALL);
        wait_cyc(12);
        check("final_level", int'(btn_level), 0);

        foreach (exp_q[j])
            check($sformatf("missing_ch%0d_k%0d_at%0d", exp_q[j].ch, exp_q[j].kind, exp_q[j].cyc), 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_debounce_array.md
# btn_debounce_array

Parametrised multi-channel push-button conditioner for the board front end. It replaces per-button hand-written edge detection logic. Each channel gets an input synchronizer, a stability-counter debouncer and a debounced level output. Each channel also gets single-cycle rising and falling edge pulses, and optionally a long-press pulse. Game/control FSMs downstream consume only the pulses and levels, never raw `buttom_*` pins.

## Interface
- `N_CH`, default 5: number of independent button channels (≥1).
- `STABLE_CYCLES`, default 130000: consecutive `clk` cycles a synchronized input must differ from the debounced level before the level flips (≥1).
- `SYNC_STAGES`, default 2: synchronizer flop depth (≥2).
- `HOLD_CYCLES`, default 100000000: cycles of continuous debounced-high level before `long_press` fires (≥1; used only with `BTN_LONG_PRESS_EN`).
- `clk`, input, 1: system clock, 100 MHz.
- `buttom_rst`, input, 1: asynchronous, active-high reset.
- `btn_raw`, input, N_CH: raw button pins, asynchronous to `clk`.
- `btn_level`, output, N_CH: debounced level per channel.
- `btn_rise`, output, N_CH: one-cycle pulse on a debounced 0→1 transition.
- `btn_fall`, output, N_CH: one-cycle pulse on a debounced 1→0 transition.
- `long_press`, output, N_CH: one-cycle pulse after a held press (see Configuration).

## Operation
- All channels are identical and fully independent; no shared counters.
- Synchronizer: `btn_raw[i]` passes through a `SYNC_STAGES` flop chain, giving `sync[i]`.
- Debounce counter `cnt[i]` is `$clog2(STABLE_CYCLES+1)` bits wide. Each edge:
  - if `sync[i] == btn_level[i]`: `cnt[i]` ← 0.
  - else if `cnt[i] == STABLE_CYCLES-1`: `btn_level[i]` ← `sync[i]` and `cnt[i]` ← 0. Assert `btn_rise[i]` (new level 1) or `btn_fall[i]` (new level 0) for exactly that one cycle.
  - else: `cnt[i]` ← `cnt[i]+1`.
- Any bounce that returns `sync` to the current level clears the count; partial counts never carry over.
- `btn_rise` and `btn_fall` of one channel are never high together. Pulses on different channels may coincide.
- Counter never wraps: the compare happens at `STABLE_CYCLES-1`, so the counter never exceeds that value.
- Per-channel state: {LOW_STABLE, LOW_CONFIRM, HIGH_STABLE, HIGH_CONFIRM}.
  - The CONFIRM states are the `cnt != 0` cases.
  - LOW_CONFIRM → HIGH_STABLE on a completed count; HIGH_CONFIRM → LOW_STABLE on a completed count.
  - CONFIRM → STABLE (same level) on a bounce.

## Timing
- Reset (async assert): synchronizer flops, `cnt`, `btn_level`, `btn_rise`, `btn_fall`, `long_press` and hold counters all go to 0 immediately.
- Reset release: no edge pulses are produced for inputs already high. Their debounced 0→1 appears normally after `STABLE_CYCLES`, so a button held through reset yields one `btn_rise`.
- Latency: `btn_raw` changes before edge 1 and stays stable. `sync` updates at edge `SYNC_STAGES`. `btn_level` and the pulse update at edge `SYNC_STAGES+STABLE_CYCLES`.
- Minimum accepted pulse width: `STABLE_CYCLES` cycles at `sync`. Anything shorter produces no output.
- Reset mid-count: the count is discarded and no pulse is emitted.

## Configuration
- Macro: `BTN_LONG_PRESS_EN`.
- Defined:
  - Per-channel hold counter, `$clog2(HOLD_CYCLES+1)` bits, cleared on the `btn_rise` cycle and while `btn_level==0`.
  - It increments each cycle `btn_level==1` and saturates at `HOLD_CYCLES`.
  - `long_press[i]` pulses one cycle at edge (rise edge + `HOLD_CYCLES`), once per press.
  - `btn_fall` before that point suppresses it.
- Undefined: no hold counters are synthesized and `long_press` is tied to 0.

## Test plan
Params: N_CH=5, STABLE_CYCLES=4, SYNC_STAGES=2, HOLD_CYCLES=10.
- Clean press: `btn_raw[0]` 0→1 before edge 1 and held → `btn_level[0]`=1 at edge 6; `btn_rise[0]`=1 only during cycle 6–7; `btn_fall`=0; other channels idle.
- Bounce: `btn_raw[1]` high for 3 cycles, low for 1, then high and held → no pulse for the 3-cycle burst; `btn_rise[1]` exactly once, 4 cycles after the final `sync` rise.
- Release plus simultaneous channels: ch2 and ch3 pressed the same cycle, later released → `btn_rise[2]`/`btn_rise[3]` pulse the same cycle; each `btn_fall` fires exactly once, 6 cycles after its release.
- Reset mid-count: assert `buttom_rst` when `cnt[4]`=2 → all outputs 0 immediately, no pulse. After release with input still high → a single `btn_rise[4]` 6 cycles later.
- Long press (macro on): hold ch0 → `long_press[0]` pulses 10 cycles after `btn_rise[0]`, once. A press released after 5 cycles → no `long_press`. Macro off → `long_press` constantly 0.
